// File: rtl/cpu_data.sv
// rtl/cpu_data.sv - shared opcode encodings, flag indices and FSM state type
// Purpose: opcode values for the binary and single-operand groups (both are
//          selected by the 4-bit operator field, the group by `single`), the
//          bit positions inside the 4-bit flags word, and the control states.
// Ports:   none (package).
package cpu_data;

  // Binary group
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_ADC = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;

  // Single-operand group
  localparam logic [3:0] OP_NEG = 4'h0;
  localparam logic [3:0] OP_COM = 4'h1;
  localparam logic [3:0] OP_LSL = 4'h2;
  localparam logic [3:0] OP_LSR = 4'h3;
  localparam logic [3:0] OP_ROL = 4'h4;
  localparam logic [3:0] OP_ROR = 4'h5;
  localparam logic [3:0] OP_RLC = 4'h6;
  localparam logic [3:0] OP_RRC = 4'h7;

  // flags = {carry, overflow, zero, negative}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    ST_IDLE,
    ST_ITER
  } state_t;

  // MUL/DIV are the only multi-cycle operations.
  function automatic logic is_iter_op(input logic single, input logic [3:0] op);
    return !single && (op == OP_MUL || op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between the execute stage and alu_seq
// Purpose: groups the request (start, single, operator, value1, value2) and the
//          response (result, result_hi, flags, busy, done).
// Ports:   master drives requests and reads results; slave is the ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             single;
  logic [3:0]       operator;
  logic [WIDTH-1:0] value1;
  logic [WIDTH-1:0] value2;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output start, single, operator, value1, value2,
    input  result, result_hi, flags, busy, done
  );

  modport slave (
    input  start, single, operator, value1, value2,
    output result, result_hi, flags, busy, done
  );
endinterface

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative unsigned multiply / restoring divide datapath
// Purpose: holds accumulator, shifted operand, second operand and step counter.
//          One step per clock after `start`; `last` marks the final step and
//          acc_next/opr_next show that step's outcome so the owner can capture it.
// Ports:   clk, rst_n, start (load operands), is_div, value1, value2 in;
//          last, div_mode, acc_next (high product / remainder),
//          opr_next (low product / quotient) out.
module alu_seq_iter
  import cpu_data::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             last,
  output logic             div_mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] opr_next
);
  logic [WIDTH-1:0] acc_q, opr_q, other_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum, shifted, trial;

  assign last     = (cnt_q == CW'(1));
  assign div_mode = div_q;

  always_comb begin
    sum      = '0;
    shifted  = '0;
    trial    = '0;
    acc_next = acc_q;
    opr_next = opr_q;
    if (div_q) begin
      // Shift the next dividend bit into the partial remainder, subtract the
      // divisor if it fits, and shift the quotient bit into opr.
      shifted = {acc_q, opr_q[WIDTH-1]};
      trial   = shifted - {1'b0, other_q};
      if (shifted >= {1'b0, other_q}) begin
        acc_next = trial[WIDTH-1:0];
        opr_next = {opr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        opr_next = {opr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // {carry, acc, opr} shifts right once per step; opr drains the multiplier
      // LSB-first while product bits fill in from the top.
      sum      = {1'b0, acc_q} + (opr_q[0] ? {1'b0, other_q} : '0);
      acc_next = sum[WIDTH:1];
      opr_next = {sum[0], opr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      opr_q   <= '0;
      other_q <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (start) begin
      acc_q   <= '0;
      opr_q   <= value1;
      other_q <= value2;
      div_q   <= is_div;
      cnt_q   <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q <= acc_next;
      opr_q <= opr_next;
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with single-cycle ops and iterative MUL/DIV
// Purpose: single-cycle binary/single-operand operators, persistent flags,
//          and a start/busy/done handshake around the MUL/DIV datapath.
// Ports:   clk, rst_n (sync, active low); bus (alu_seq_if.slave): start,
//          single, operator, value1, value2 in; result, result_hi, flags,
//          busy, done out.
module alu_seq
  import cpu_data::*;
#(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             iter_start, iter_last, iter_div;
  logic [WIDTH-1:0] iter_lo, iter_hi;
  logic [WIDTH-1:0] v1, v2, alu_res;
  logic             alu_c, alu_v, alu_keep, single_ok, c_in;
  logic [WIDTH:0]   sum, diff;

  assign v1   = bus.value1;
  assign v2   = bus.value2;
  assign c_in = flags_q[FLAG_C];

  alu_seq_iter #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
    .is_div   (bus.operator == OP_DIV),
    .value1   (v1),
    .value2   (v2),
    .last     (iter_last),
    .div_mode (iter_div),
    .acc_next (iter_hi),
    .opr_next (iter_lo)
  );

  // Single-cycle operator evaluation; alu_keep marks CMP, which updates flags only.
  always_comb begin
    sum       = {1'b0, v1} + {1'b0, v2} + {{WIDTH{1'b0}}, (bus.operator == OP_ADC) & c_in};
    diff      = {1'b0, v1} - {1'b0, v2} - {{WIDTH{1'b0}}, (bus.operator == OP_SBC) & c_in};
    alu_res   = '0;
    alu_c     = c_in;
    alu_v     = 1'b0;
    alu_keep  = 1'b0;
    single_ok = 1'b0;
    if (!bus.single) begin
      case (bus.operator)
        OP_ADD, OP_ADC: begin
          alu_res = sum[MSB:0];
          alu_c   = sum[WIDTH];
          alu_v   = (v1[MSB] == v2[MSB]) && (sum[MSB] != v1[MSB]);
        end
        OP_SUB, OP_SBC, OP_CMP: begin
          alu_res  = diff[MSB:0];
          alu_c    = diff[WIDTH];
          alu_v    = (v1[MSB] != v2[MSB]) && (diff[MSB] != v1[MSB]);
          alu_keep = (bus.operator == OP_CMP);
        end
        OP_AND:  alu_res = v1 & v2;
        OP_OR:   alu_res = v1 | v2;
        OP_XOR:  alu_res = v1 ^ v2;
        OP_MOV:  alu_res = v2;
        default: ;
      endcase
    end else begin
      single_ok = 1'b1;
      case (bus.operator)
        OP_NEG: begin alu_res = '0 - v1; alu_c = |v1; end
        OP_COM:  alu_res = ~v1;
        OP_LSL: begin alu_res = {v1[MSB-1:0], 1'b0}; alu_c = v1[MSB]; end
        OP_LSR: begin alu_res = {1'b0, v1[MSB:1]};   alu_c = v1[0];   end
        OP_ROL:  alu_res = {v1[MSB-1:0], v1[MSB]};
        OP_ROR:  alu_res = {v1[0], v1[MSB:1]};
        OP_RLC: begin alu_res = {v1[MSB-1:0], c_in}; alu_c = v1[MSB]; end
        OP_RRC: begin alu_res = {c_in, v1[MSB:1]};   alu_c = v1[0];   end
        default: single_ok = 1'b0;
      endcase
      alu_v = single_ok & (v1[MSB] ^ alu_res[MSB]);
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    hi_d       = hi_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (!bus.single && bus.operator == OP_DIV && v2 == '0) begin
            result_d        = '1;
            hi_d            = v1;
            flags_d         = '0;
            flags_d[FLAG_V] = 1'b1;
            flags_d[FLAG_N] = 1'b1;
            done_d          = 1'b1;
          end else if (is_iter_op(bus.single, bus.operator)) begin
            iter_start = 1'b1;
            state_d    = ST_ITER;
          end else begin
            if (!alu_keep) begin
              result_d = alu_res;
              hi_d     = '0;
            end
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_V] = alu_v;
            flags_d[FLAG_Z] = ~|alu_res;
            flags_d[FLAG_N] = alu_res[MSB];
            done_d          = 1'b1;
          end
        end
      end
      ST_ITER: begin
        if (iter_last) begin
          result_d        = iter_lo;
          hi_d            = iter_hi;
          flags_d[FLAG_C] = !iter_div && (iter_hi != '0);
          flags_d[FLAG_V] = 1'b0;
          flags_d[FLAG_Z] = ~|iter_lo;
          flags_d[FLAG_N] = iter_lo[MSB];
          done_d          = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.result_hi = hi_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = (state_q == ST_ITER);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed-vector bench for alu_seq at WIDTH 8 and 16
module tb_alu_seq;
  import cpu_data::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  // Request accepted at the posedge inside; returns #1 after it with operands scrambled.
  task automatic issue(input logic s, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.single = s; bus.operator = op; bus.value1 = a; bus.value2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.value1 = 8'hA5; bus.value2 = 8'h3C;
  endtask

  // edges: clock edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 0; busy_cyc = 0;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags, bus.busy, bus.done} !== 22'h0) begin
      n_err++; $display("FAIL reset_w8: got %h want 0", {bus.result, bus.result_hi, bus.flags, bus.busy, bus.done});
    end
    n_vec++;
    if ({bus16.result, bus16.result_hi, bus16.flags, bus16.busy, bus16.done} !== 38'h0) begin
      n_err++; $display("FAIL reset_w16: got %h want 0", {bus16.result, bus16.result_hi, bus16.flags, bus16.busy, bus16.done});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    int e, b;
    issue(1'b0, OP_ADD, 8'h7F, 8'h01); wait_done(e, b);
    n_vec++;
    if (e !== 0) begin n_err++; $display("FAIL add_latency: got %0d want 0 extra edges", e); end
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags} !== {8'h80, 8'h00, 4'b0101}) begin
      n_err++; $display("FAIL add_7f_01: got %h want %h", {bus.result, bus.result_hi, bus.flags}, {8'h80, 8'h00, 4'b0101});
    end
    issue(1'b0, OP_SUB, 8'h00, 8'h01); wait_done(e, b);
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags} !== {8'hFF, 8'h00, 4'b1001}) begin
      n_err++; $display("FAIL sub_00_01: got %h want %h", {bus.result, bus.result_hi, bus.flags}, {8'hFF, 8'h00, 4'b1001});
    end
  endtask

  task automatic test_carry_chain();
    int e, b;
    logic [3:0]  ops [6] = '{OP_ADD, OP_ADC, OP_CMP, OP_AND, OP_SBC, 4'hE};
    logic [7:0]  as  [6] = '{8'hFF, 8'h00, 8'h05, 8'h0F, 8'h10, 8'h12};
    logic [7:0]  bs  [6] = '{8'h01, 8'h00, 8'h07, 8'hF0, 8'h05, 8'h34};
    logic [19:0] exp [6] = '{{8'h00, 8'h00, 4'b1010},   // carry out, zero
                             {8'h01, 8'h00, 4'b0000},   // 0+0+C
                             {8'h01, 8'h00, 4'b1001},   // CMP keeps result, borrow, diff negative
                             {8'h00, 8'h00, 4'b1010},   // carry from CMP preserved
                             {8'h0A, 8'h00, 4'b0000},   // 0x10-0x05-C
                             {8'h00, 8'h00, 4'b0010}};  // unused binary opcode
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, ops[i], as[i], bs[i]); wait_done(e, b);
      n_vec++;
      if ({bus.result, bus.result_hi, bus.flags} !== exp[i]) begin
        n_err++; $display("FAIL chain_%0d op %h: got %h want %h", i, ops[i], {bus.result, bus.result_hi, bus.flags}, exp[i]);
      end
    end
  endtask

  task automatic test_mul();
    int e = 0, b = 0;
    issue(1'b0, OP_MUL, 8'h10, 8'h20);
    while (!bus.done && e < 40) begin
      if (bus.busy) b++;
      @(negedge clk);
      bus.start = (e == 2 || e == 5); bus.single = 1'b0; bus.operator = OP_ADD;
      @(posedge clk); #1;
      bus.start = 1'b0;
      e++;
    end
    n_vec++;
    if (e !== 8) begin n_err++; $display("FAIL mul_latency: got %0d want 8", e); end
    n_vec++;
    if (b !== 8) begin n_err++; $display("FAIL mul_busy_cycles: got %0d want 8", b); end
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags} !== {8'h00, 8'h02, 4'b1010}) begin
      n_err++; $display("FAIL mul_10_20: got %h want %h", {bus.result, bus.result_hi, bus.flags}, {8'h00, 8'h02, 4'b1010});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.done, bus.busy, bus.result_hi} !== {1'b0, 1'b0, 8'h02}) begin
      n_err++; $display("FAIL mul_after_done: got %h want %h", {bus.done, bus.busy, bus.result_hi}, {1'b0, 1'b0, 8'h02});
    end
  endtask

  task automatic test_div();
    int e, b;
    issue(1'b0, OP_DIV, 8'd200, 8'd7); wait_done(e, b);
    n_vec++;
    if (e !== 8) begin n_err++; $display("FAIL div_latency: got %0d want 8", e); end
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags} !== {8'h1C, 8'h04, 4'b0000}) begin
      n_err++; $display("FAIL div_200_7: got %h want %h", {bus.result, bus.result_hi, bus.flags}, {8'h1C, 8'h04, 4'b0000});
    end
    issue(1'b0, OP_DIV, 8'h55, 8'h00); wait_done(e, b);
    n_vec++;
    if (e !== 0 || b !== 0) begin n_err++; $display("FAIL div0_latency: got %0d/%0d want 0/0", e, b); end
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags} !== {8'hFF, 8'h55, 4'b0101}) begin
      n_err++; $display("FAIL div0_55: got %h want %h", {bus.result, bus.result_hi, bus.flags}, {8'hFF, 8'h55, 4'b0101});
    end
  endtask

  task automatic test_back_to_back();
    int e, b;
    issue(1'b0, OP_XOR, 8'h0F, 8'hFF); wait_done(e, b);
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags} !== {8'hF0, 8'h00, 4'b0001}) begin
      n_err++; $display("FAIL b2b_xor: got %h want %h", {bus.result, bus.result_hi, bus.flags}, {8'hF0, 8'h00, 4'b0001});
    end
    issue(1'b0, OP_MOV, 8'h00, 8'h3C);
    n_vec++;
    if ({bus.done, bus.result, bus.flags} !== {1'b1, 8'h3C, 4'b0000}) begin
      n_err++; $display("FAIL b2b_mov: got %h want %h", {bus.done, bus.result, bus.flags}, {1'b1, 8'h3C, 4'b0000});
    end
  endtask

  task automatic test_abort();
    int e, b;
    issue(1'b0, OP_MUL, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.result, bus.result_hi, bus.flags, bus.busy, bus.done} !== 22'h0) begin
      n_err++; $display("FAIL abort_mul: got %h want 0", {bus.result, bus.result_hi, bus.flags, bus.busy, bus.done});
    end
    @(negedge clk);
    bus.start = 1'b1; bus.single = 1'b0; bus.operator = OP_ADD; bus.value1 = 8'h01; bus.value2 = 8'h01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_vec++;
    if ({bus.done, bus.busy, bus.result} !== 10'h0) begin
      n_err++; $display("FAIL reset_beats_start: got %h want 0", {bus.done, bus.busy, bus.result});
    end
    @(negedge clk); rst_n = 1'b1;
    issue(1'b1, OP_LSL, 8'h81, 8'h00); wait_done(e, b);
    n_vec++;
    if (e !== 0 || {bus.result, bus.result_hi, bus.flags} !== {8'h02, 8'h00, 4'b1100}) begin
      n_err++; $display("FAIL post_reset_lsl: got %0d %h want 0 %h", e, {bus.result, bus.result_hi, bus.flags}, {8'h02, 8'h00, 4'b1100});
    end
  endtask

  task automatic test_single();
    int e, b;
    logic [3:0]  ops [8] = '{OP_LSR, OP_RRC, OP_NEG, OP_COM, OP_ROL, OP_RLC, OP_ROR, 4'hF};
    logic [7:0]  as  [8] = '{8'h01, 8'h00, 8'h01, 8'h0F, 8'h80, 8'h40, 8'h01, 8'h80};
    logic [11:0] exp [8] = '{{8'h00, 4'b1010}, {8'h80, 4'b0101}, {8'hFF, 4'b1101}, {8'hF0, 4'b1101},
                             {8'h01, 4'b1100}, {8'h81, 4'b0101}, {8'h80, 4'b0101}, {8'h00, 4'b0010}};
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, ops[i], as[i], 8'hFF); wait_done(e, b);
      n_vec++;
      if ({bus.result, bus.flags} !== exp[i] || bus.result_hi !== 8'h00) begin
        n_err++; $display("FAIL single_%0d op %h: got %h/%h want %h/00", i, ops[i], {bus.result, bus.flags}, bus.result_hi, exp[i]);
      end
    end
  endtask

  task automatic test_width16();
    int e = 0;
    @(negedge clk);
    bus16.start = 1'b1; bus16.single = 1'b0; bus16.operator = OP_MUL;
    bus16.value1 = 16'h0100; bus16.value2 = 16'h0100;
    @(posedge clk); #1;
    bus16.start = 1'b0; bus16.value1 = 16'h0; bus16.value2 = 16'h0;
    while (!bus16.done && e < 60) begin
      @(posedge clk); #1;
      e++;
    end
    n_vec++;
    if (e !== 16) begin n_err++; $display("FAIL w16_mul_latency: got %0d want 16", e); end
    n_vec++;
    if ({bus16.result, bus16.result_hi, bus16.flags} !== {16'h0000, 16'h0001, 4'b1010}) begin
      n_err++; $display("FAIL w16_mul: got %h want %h", {bus16.result, bus16.result_hi, bus16.flags}, {16'h0000, 16'h0001, 4'b1010});
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.single = 1'b0; bus.operator = 4'h0; bus.value1 = 8'h0; bus.value2 = 8'h0;
    bus16.start = 1'b0; bus16.single = 1'b0; bus16.operator = 4'h0; bus16.value1 = 16'h0; bus16.value2 = 16'h0;
    test_reset();
    test_add_sub();
    test_carry_chain();
    test_mul();
    test_div();
    test_back_to_back();
    test_abort();
    test_single();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
